// File: rtl/tia_pkg.sv
// Shared definitions for the TIA video path: collision bit map, colour
// defaults and the object bundle used by the mixer.
package tia_pkg;

    localparam int DEFAULT_COLOR_WIDTH = 7;
    localparam int BLANK_COLOR         = 0;
    localparam int NUM_COLLISIONS      = 15;

    localparam int CX_M0_P1 = 0;
    localparam int CX_M0_P0 = 1;
    localparam int CX_M1_P0 = 2;
    localparam int CX_M1_P1 = 3;
    localparam int CX_P0_PF = 4;
    localparam int CX_P0_BL = 5;
    localparam int CX_P1_PF = 6;
    localparam int CX_P1_BL = 7;
    localparam int CX_M0_PF = 8;
    localparam int CX_M0_BL = 9;
    localparam int CX_M1_PF = 10;
    localparam int CX_M1_BL = 11;
    localparam int CX_BL_PF = 12;
    localparam int CX_P0_P1 = 13;
    localparam int CX_M0_M1 = 14;

    typedef struct packed {
        logic player0;
        logic player1;
        logic missile0;
        logic missile1;
        logic ball;
        logic playfield;
    } objects_t;

    // Pairwise coincidences of one pixel's objects, in CXxx register order.
    function automatic logic [NUM_COLLISIONS-1:0] collision_hits(input objects_t o);
        logic [NUM_COLLISIONS-1:0] h;
        h           = '0;
        h[CX_M0_P1] = o.missile0 & o.player1;
        h[CX_M0_P0] = o.missile0 & o.player0;
        h[CX_M1_P0] = o.missile1 & o.player0;
        h[CX_M1_P1] = o.missile1 & o.player1;
        h[CX_P0_PF] = o.player0  & o.playfield;
        h[CX_P0_BL] = o.player0  & o.ball;
        h[CX_P1_PF] = o.player1  & o.playfield;
        h[CX_P1_BL] = o.player1  & o.ball;
        h[CX_M0_PF] = o.missile0 & o.playfield;
        h[CX_M0_BL] = o.missile0 & o.ball;
        h[CX_M1_PF] = o.missile1 & o.playfield;
        h[CX_M1_BL] = o.missile1 & o.ball;
        h[CX_BL_PF] = o.ball     & o.playfield;
        h[CX_P0_P1] = o.player0  & o.player1;
        h[CX_M0_M1] = o.missile0 & o.missile1;
        return h;
    endfunction

endpackage

// File: rtl/object_priority.sv
// Combinational priority resolver: picks one colour from the gated object
// pixels, the CTRLPF priority/score bits and the four colour registers.
module object_priority
    import tia_pkg::*;
#(
    parameter int COLOR_WIDTH = DEFAULT_COLOR_WIDTH
) (
    input  logic                   player0,
    input  logic                   player1,
    input  logic                   missile0,
    input  logic                   missile1,
    input  logic                   ball,
    input  logic                   playfield,
    input  logic                   pf_priority,
    input  logic                   score_mode,
    input  logic                   right_half,
    input  logic [COLOR_WIDTH-1:0] colup0,
    input  logic [COLOR_WIDTH-1:0] colup1,
    input  logic [COLOR_WIDTH-1:0] colupf,
    input  logic [COLOR_WIDTH-1:0] colubk,
    output logic [COLOR_WIDTH-1:0] color
);

    logic                   group0;
    logic                   group1;
    logic                   group_pf;
    logic [COLOR_WIDTH-1:0] pf_color;

    assign group0   = player0 | missile0;
    assign group1   = player1 | missile1;
    assign group_pf = ball | playfield;

    // Score mode recolours playfield by half; the ball keeps colupf and wins.
    always_comb begin
        // NOTE: assign every combinational output a default first so no path can infer a latch.
        pf_color = colupf;
        if (score_mode && !pf_priority && !ball && playfield) begin
            pf_color = right_half ? colup1 : colup0;
        end
    end

    always_comb begin
        color = colubk;
        if (pf_priority) begin
            if (group_pf)    color = colupf;
            else if (group0) color = colup0;
            else if (group1) color = colup1;
        end else begin
            if (group0)        color = colup0;
            else if (group1)   color = colup1;
            else if (group_pf) color = pf_color;
        end
    end

endmodule

// File: rtl/object_mixer.sv
// Registers the resolved pixel colour for the video encoder and latches the
// fifteen sticky pairwise collision flags read and cleared by the CPU.
module object_mixer
    import tia_pkg::*;
#(
    parameter int COLOR_WIDTH = DEFAULT_COLOR_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      player0,
    input  logic                      player1,
    input  logic                      missile0,
    input  logic                      missile1,
    input  logic                      ball,
    input  logic                      playfield,
    input  logic                      visible,
    input  logic                      right_half,
    input  logic [COLOR_WIDTH-1:0]    colup0,
    input  logic [COLOR_WIDTH-1:0]    colup1,
    input  logic [COLOR_WIDTH-1:0]    colupf,
    input  logic [COLOR_WIDTH-1:0]    colubk,
    input  logic                      pf_priority,
    input  logic                      score_mode,
    input  logic                      collision_clear,
    output logic [COLOR_WIDTH-1:0]    color_out,
    output logic                      color_valid,
    output logic [NUM_COLLISIONS-1:0] collisions
);

    objects_t                  obj;
    logic [COLOR_WIDTH-1:0]    prio_color;
    logic [NUM_COLLISIONS-1:0] hits;

    // Outside the active picture every object reads as absent.
    assign obj.player0   = player0   & visible;
    assign obj.player1   = player1   & visible;
    assign obj.missile0  = missile0  & visible;
    assign obj.missile1  = missile1  & visible;
    assign obj.ball      = ball      & visible;
    assign obj.playfield = playfield & visible;

    assign hits = collision_hits(obj);

    object_priority #(
        .COLOR_WIDTH (COLOR_WIDTH)
    ) u_object_priority (
        .player0     (obj.player0),
        .player1     (obj.player1),
        .missile0    (obj.missile0),
        .missile1    (obj.missile1),
        .ball        (obj.ball),
        .playfield   (obj.playfield),
        .pf_priority (pf_priority),
        .score_mode  (score_mode),
        .right_half  (right_half),
        .colup0      (colup0),
        .colup1      (colup1),
        .colupf      (colupf),
        .colubk      (colubk),
        .color       (prio_color)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            color_out   <= COLOR_WIDTH'(BLANK_COLOR);
            color_valid <= 1'b0;
        end else begin
            color_out   <= visible ? prio_color : COLOR_WIDTH'(BLANK_COLOR);
            color_valid <= visible;
        end
    end

    // Clear takes precedence: coincidences in the CXCLR cycle are dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            collisions <= '0;
        end else if (collision_clear) begin
            collisions <= '0;
        end else begin
            collisions <= collisions | hits;
        end
    end

endmodule

// File: tb/tb_object_mixer.sv
// Self-checking bench for object_mixer: a reference model pushes expected
// pixels into a scoreboard queue that is popped after each clock edge.
module tb_object_mixer;

    localparam int CW = 7;

    typedef struct packed {
        logic p0, p1, m0, m1, bl, pf;
        logic vis, rh, pri, score, clr;
    } stim_t;

    typedef struct packed {
        logic [CW-1:0] color;
        logic          valid;
        logic [14:0]   coll;
    } expect_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          player0 = 0, player1 = 0, missile0 = 0, missile1 = 0;
    logic          ball = 0, playfield = 0, visible = 0, right_half = 0;
    logic [CW-1:0] colup0 = '0, colup1 = '0, colupf = '0, colubk = '0;
    logic          pf_priority = 0, score_mode = 0, collision_clear = 0;
    logic [CW-1:0] color_out;
    logic          color_valid;
    logic [14:0]   collisions;

    int            errors = 0;
    int            checks = 0;
    expect_t       sb_q[$];
    logic [14:0]   coll_model = '0;

    // Object index per collision bit: 0 P0, 1 P1, 2 M0, 3 M1, 4 BL, 5 PF.
    int pair_a[15] = '{2, 2, 3, 3, 0, 0, 1, 1, 2, 2, 3, 3, 4, 0, 2};
    int pair_b[15] = '{1, 0, 0, 1, 5, 4, 5, 4, 5, 4, 5, 4, 5, 1, 3};

    object_mixer #(.COLOR_WIDTH(CW)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .player0         (player0),
        .player1         (player1),
        .missile0        (missile0),
        .missile1        (missile1),
        .ball            (ball),
        .playfield       (playfield),
        .visible         (visible),
        .right_half      (right_half),
        .colup0          (colup0),
        .colup1          (colup1),
        .colupf          (colupf),
        .colubk          (colubk),
        .pf_priority     (pf_priority),
        .score_mode      (score_mode),
        .collision_clear (collision_clear),
        .color_out       (color_out),
        .color_valid     (color_valid),
        .collisions      (collisions)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic stim_t mk(input logic p0, p1, m0, m1, bl, pf, vis, rh, pri, score, clr);
        stim_t s;
        s = '{p0, p1, m0, m1, bl, pf, vis, rh, pri, score, clr};
        return s;
    endfunction

    function automatic logic [CW-1:0] model_color(input stim_t s);
        logic g0, g1, gpf;
        if (!s.vis) return '0;
        g0  = s.p0 | s.m0;
        g1  = s.p1 | s.m1;
        gpf = s.bl | s.pf;
        if (s.pri) begin
            if (gpf) return colupf;
            if (g0)  return colup0;
            if (g1)  return colup1;
            return colubk;
        end
        if (g0) return colup0;
        if (g1) return colup1;
        if (s.bl) return colupf;
        if (s.pf) return s.score ? (s.rh ? colup1 : colup0) : colupf;
        return colubk;
    endfunction

    function automatic logic [14:0] model_hits(input stim_t s);
        logic [5:0]  o;
        logic [14:0] h;
        o = {s.pf, s.bl, s.m1, s.m0, s.p1, s.p0};
        h = '0;
        if (s.vis)
            for (int i = 0; i < 15; i++) h[i] = o[pair_a[i]] & o[pair_b[i]];
        return h;
    endfunction

    task automatic step(input string tag, input stim_t s);
        expect_t e, got;
        @(negedge clk);
        {player0, player1, missile0, missile1, ball, playfield} = {s.p0, s.p1, s.m0, s.m1, s.bl, s.pf};
        visible         = s.vis;
        right_half      = s.rh;
        pf_priority     = s.pri;
        score_mode      = s.score;
        collision_clear = s.clr;
        coll_model      = s.clr ? 15'h0 : (coll_model | model_hits(s));
        e.color = model_color(s);
        e.valid = s.vis;
        e.coll  = coll_model;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 1, 0);
        end else begin
            got = sb_q.pop_front();
            check({tag, "_color"}, color_out, got.color);
            check({tag, "_valid"}, color_valid, got.valid);
            check({tag, "_coll"}, collisions, got.coll);
        end
    endtask

    stim_t idle;

    initial begin
        idle = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_color", color_out, 0);
        check("rst_valid", color_valid, 0);
        check("rst_coll", collisions, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Basic priority, pf_priority 0 then 1.
        colup0 = 7'h44; colup1 = 7'h74; colupf = 7'h1E; colubk = 7'h2A;
        step("p0pf_pri0", mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        check("p0pf_bit4", collisions[4], 1);
        step("p0pf_pri1", mk(1, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0));
        step("p1_only", mk(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        step("m1bl_pri0", mk(0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0));
        step("bg", idle);

        // Score mode on playfield, both halves, then with playfield priority.
        colup0 = 7'h32; colup1 = 7'h74;
        step("score_left", mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0));
        step("score_right", mk(0, 0, 0, 0, 0, 1, 1, 1, 0, 1, 0));
        step("score_pri_l", mk(0, 0, 0, 0, 0, 1, 1, 0, 1, 1, 0));
        step("score_pri_r", mk(0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 0));
        step("score_ball", mk(0, 0, 0, 0, 1, 1, 1, 1, 0, 1, 0));
        step("score_p1", mk(0, 1, 0, 0, 0, 1, 1, 1, 0, 1, 0));

        // Blanking: all objects high while invisible.
        step("blank", mk(1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0));

        // Missiles and players together, after a clear.
        step("clr0", mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1));
        step("mp4", mk(1, 1, 1, 1, 0, 0, 1, 0, 0, 0, 0));
        check("mp4_const", collisions, 15'h600F);
        for (int i = 0; i < 100; i++) step("hold", idle);
        check("hold_const", collisions, 15'h600F);

        // Clear coincident with BL-PF, then BL-PF again.
        step("clr_blpf", mk(0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1));
        check("clr_const", collisions, 15'h0000);
        step("blpf", mk(0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0));
        check("blpf_const", collisions, 15'h1000);

        // A few random pixels against the model.
        for (int i = 0; i < 40; i++) begin
            stim_t r;
            r = stim_t'($urandom_range(0, 2047));
            r.clr = ($urandom_range(0, 7) == 0);
            colup0 = 7'($urandom); colup1 = 7'($urandom);
            colupf = 7'($urandom); colubk = 7'($urandom);
            step("rand", r);
        end

        // Set every flag, put 0x2A on the output, then reset between edges.
        colubk = 7'h2A;
        step("all_on", mk(1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0));
        check("all_const", collisions, 15'h7FFF);
        step("bg2a", idle);
        check("bg2a_const", color_out, 7'h2A);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_color", color_out, 0);
        check("async_valid", color_valid, 0);
        check("async_coll", collisions, 0);
        coll_model = '0;
        @(negedge clk);
        reset_n = 1'b1;
        step("post_rst", idle);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
